// File: rtl/fpdiv_iter.sv
// Iterative binary16 divider: restoring division, one quotient bit per cycle, 14-cycle latency.
// Define FPDIV_EARLY_EXIT_EN to finish flushed requests (Inf/NaN/zero/denormal operands) early.
module fpdiv_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] opA_i,
    input  logic [15:0] opB_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] DIV_o
);

    typedef enum logic [1:0] {StIdle, StDiv, StRound} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [11:0] rem_q;
    logic [12:0] q_q;
    logic [10:0] mb_q;
    logic [4:0]  ea_q, eb_q;
    logic        sign_q, flush_q, done_q;
    logic [15:0] div_q;

    logic        accept, op_flush;
    logic        ge;
    logic [11:0] diff, rem_next;
    logic        norm, guard, carry, underflow, overflow;
    logic [9:0]  mant_raw;
    logic [10:0] mant_rnd;
    logic [6:0]  exp_v;
    logic [15:0] result;

    // A start during the done cycle is still treated as busy and dropped.
    assign accept   = (state_q == StIdle) && start_i && !done_q;
    assign op_flush = (&opA_i[14:10]) || (~|opA_i[14:10]) ||
                      (&opB_i[14:10]) || (~|opB_i[14:10]);

    assign ge       = rem_q >= {1'b0, mb_q};
    assign diff     = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    assign rem_next = {diff[10:0], 1'b0};

    always_comb begin
        norm     = q_q[12];
        mant_raw = norm ? q_q[11:2] : q_q[10:1];
        guard    = norm ? q_q[1] : q_q[0];
        mant_rnd = {1'b0, mant_raw} + {10'd0, guard};
        carry    = mant_rnd[10];
        // 7-bit two's complement exponent; range stays within -15..45.
        exp_v     = {2'b00, ea_q} - {2'b00, eb_q} + 7'd15 - {6'd0, ~norm} + {6'd0, carry};
        underflow = exp_v[6] || (exp_v == 7'd0);
        overflow  = !exp_v[6] && (exp_v >= 7'd31);
        if (flush_q || underflow || overflow) begin
            result = 16'h0000;
        end else begin
            result = {sign_q, exp_v[4:0], mant_rnd[9:0]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef FPDIV_EARLY_EXIT_EN
                    state_d = op_flush ? StRound : StDiv;
`else
                    state_d = StDiv;
`endif
                end
            end
            StDiv:   if (cnt_q == 4'd12) state_d = StRound;
            StRound: if (cnt_q == 4'd13) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q != StIdle) || done_q;
        done_o = done_q;
        DIV_o  = div_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= 4'd0;
            rem_q   <= 12'd0;
            q_q     <= 13'd0;
            mb_q    <= 11'd0;
            ea_q    <= 5'd0;
            eb_q    <= 5'd0;
            sign_q  <= 1'b0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            div_q   <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                rem_q   <= {2'b01, opA_i[9:0]};
                mb_q    <= {1'b1, opB_i[9:0]};
                ea_q    <= opA_i[14:10];
                eb_q    <= opB_i[14:10];
                sign_q  <= opA_i[15] ^ opB_i[15];
                flush_q <= op_flush;
                q_q     <= 13'd0;
`ifdef FPDIV_EARLY_EXIT_EN
                // Entering ROUND one count early gives it the same two-step exit.
                cnt_q   <= op_flush ? 4'd12 : 4'd0;
`else
                cnt_q   <= 4'd0;
`endif
            end else if (state_q == StDiv) begin
                rem_q <= rem_next;
                q_q   <= {q_q[11:0], ge};
                cnt_q <= cnt_q + 4'd1;
            end else if (state_q == StRound) begin
                if (cnt_q == 4'd13) begin
                    done_q <= 1'b1;
                    div_q  <= result;
                    cnt_q  <= 4'd0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpdiv_iter.sv
// Directed bench for fpdiv_iter: known quotients, flush cases, latency, ignored start and reset abort.
`timescale 1ns/1ps
module tb_fpdiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = 16'h0000;
    logic [15:0] op_b = 16'h0000;
    logic        busy, done;
    logic [15:0] div_res;

    int checks = 0;
    int errors = 0;

`ifdef FPDIV_EARLY_EXIT_EN
    localparam int FlushLat = 2;
`else
    localparam int FlushLat = 14;
`endif

    fpdiv_iter dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .opA_i   (op_a),
        .opB_i   (op_b),
        .busy_o  (busy),
        .done_o  (done),
        .DIV_o   (div_res)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res,
                          input int exp_lat, input bit inject, input string tag);
        int lat;
        int extra;
        bit busy_ok;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = 16'h4E00;
        op_b  = 16'h3800;
        checks++;
        assert (busy === 1'b1) else begin
            errors++;
            $error("FAIL %s busy_at_accept got %b want 1", tag, busy);
        end
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) lat = k;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (inject && k == 4) begin
                op_a  = 16'h3C00;
                op_b  = 16'h4200;
                start = 1'b1;
            end
            if (inject && k == 5) start = 1'b0;
        end
        checks++;
        assert (lat === exp_lat) else begin
            errors++;
            $error("FAIL %s latency got %0d want %0d", tag, lat, exp_lat);
        end
        checks++;
        assert (div_res === exp_res) else begin
            errors++;
            $error("FAIL %s result got %h want %h", tag, div_res, exp_res);
        end
        checks++;
        assert (busy_ok === 1'b1) else begin
            errors++;
            $error("FAIL %s busy_during_op got %b want 1", tag, busy_ok);
        end
        @(posedge clk);
        #1;
        checks++;
        assert ({done, busy} === 2'b00) else begin
            errors++;
            $error("FAIL %s after_done done/busy got %b%b want 00", tag, done, busy);
        end
        checks++;
        assert (div_res === exp_res) else begin
            errors++;
            $error("FAIL %s result_hold got %h want %h", tag, div_res, exp_res);
        end
        if (inject) begin
            extra = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) extra++;
            end
            checks++;
            assert (extra === 0) else begin
                errors++;
                $error("FAIL %s extra_done got %0d want 0", tag, extra);
            end
        end
    endtask

    initial begin
        int pulses;
        #12;
        checks++;
        assert ({busy, done, div_res} === 18'h0) else begin
            errors++;
            $error("FAIL reset_state got busy=%b done=%b div=%h want 0/0/0000", busy, done, div_res);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h4000, 16'h3C00, 16'h4000, 14, 1'b0, "two_div_one");
        run_op(16'h3C00, 16'h4200, 16'h3555, 14, 1'b0, "one_div_three");
        run_op(16'h4500, 16'h4200, 16'h3EAB, 14, 1'b0, "five_div_three");
        run_op(16'hC500, 16'h4000, 16'hC100, 14, 1'b0, "neg_five_div_two");
        run_op(16'h4000, 16'h0000, 16'h0000, FlushLat, 1'b0, "div_by_zero");
        run_op(16'h7C00, 16'h4000, 16'h0000, FlushLat, 1'b0, "inf_dividend");
        run_op(16'h0000, 16'h4000, 16'h0000, FlushLat, 1'b0, "zero_dividend");
        run_op(16'h7BFF, 16'h0400, 16'h0000, 14, 1'b0, "overflow");
        run_op(16'h0400, 16'h7800, 16'h0000, 14, 1'b0, "underflow");
        run_op(16'h4000, 16'h3C00, 16'h4000, 14, 1'b1, "start_while_busy");

        // Abort a 1/3 request at N+7 with an asynchronous reset.
        @(negedge clk);
        op_a  = 16'h3C00;
        op_b  = 16'h4200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        assert ({busy, done, div_res} === 18'h0) else begin
            errors++;
            $error("FAIL async_reset got busy=%b done=%b div=%h want 0/0/0000", busy, done, div_res);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        assert (pulses === 0) else begin
            errors++;
            $error("FAIL reset_no_done got %0d pulses want 0", pulses);
        end
        run_op(16'h3C00, 16'h4200, 16'h3555, 14, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpdiv_iter.md
# fpdiv_iter

Sequential half-precision (IEEE-754 binary16 layout) floating-point divider, the inverse companion to the team's combinational FP16 multiplier. It accepts two 16-bit operands on a start pulse and computes opA_i / opB_i with an iterative restoring divider, one quotient bit per cycle. It pulses done_o with the registered result. Special-value handling matches the multiplier: every exceptional case flushes to 0x0000.

## Interface
- No parameters. Format fixed: 1 sign, 5 exponent (bias 15), 10 fraction bits.
- clk_i  input  1  clock, all state updates on the rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- opA_i  input  16  dividend; sampled on the accepting edge
- opB_i  input  16  divisor; sampled on the accepting edge
- busy_o  output  1  high from the accepting edge until done_o deasserts
- done_o  output  1  single-cycle pulse; DIV_o is valid in that cycle
- DIV_o  output  16  result; holds its value until the next done_o

## Operation
- States: IDLE, DIV, ROUND. IDLE + start_i → latch operands, go to DIV, iteration counter = 0. DIV runs 13 cycles, then → ROUND. ROUND runs 1 cycle: write DIV_o, pulse done_o, → IDLE.
- Special cases, decided at latch time into a flush flag:
  - Any operand exponent = 31 (Inf/NaN) → 0x0000.
  - Any operand exponent = 0 (zero or denormal, treated as zero) → 0x0000.
  - This includes divide-by-zero and 0/x.
- Sign: signA XOR signB. It is discarded on flush; the flush result is always +0.
- Significands: mA = {1, fracA}, mB = {1, fracB}, each 11 bits. The partial remainder is 12 bits, initialised to mA.
- Each DIV cycle produces one quotient bit:
  - If rem ≥ mB: q bit = 1 and rem −= mB; otherwise q bit = 0.
  - Then rem <<= 1.
  - Bits are shifted into q[12:0], MSB first. q[12] is the integer bit.
- Normalise, then round in ROUND:
  - q[12] = 1: mant = q[11:2], guard = q[1].
  - q[12] = 0 (q[11] is then 1): mant = q[10:1], guard = q[0].
  - Rounding is round-half-up on guard. Binary16 division cannot produce an exact tie, so this equals round-to-nearest-even.
  - If the round carries out of mant: mant = 0 and exponent +1.
- Exponent: 7-bit signed, e = eA − eB + 15 − (q[12] ? 0 : 1) + roundcarry.
  - e ≤ 0 (underflow) → 0x0000.
  - e ≥ 31 (overflow) → 0x0000.
  - Otherwise DIV_o = {sign, e[4:0], mant}.
- start_i while busy_o = 1 is ignored. The operands are not re-sampled.

## Timing
- Reset values: state = IDLE, busy_o = 0, done_o = 0, DIV_o = 0x0000, quotient, remainder and counter = 0.
- Start accepted at edge N:
  - DIV iterations occupy edges N+1..N+13.
  - DIV_o and done_o update at edge N+14. done_o is high for exactly one cycle.
  - busy_o is high from N through the done_o cycle.
  - Latency is 14 cycles.
- Back-to-back: start_i held high during the done_o cycle is not accepted. Acceptance requires IDLE, so the earliest next accept is edge N+15.
- Reset asserted mid-operation: immediate return to IDLE with all reset values. The pending result is lost and no done_o is produced.
- DIV_o is stable between done pulses. Operand input changes after acceptance have no effect.

## Configuration
- FPDIV_EARLY_EXIT_EN defined:
  - A flush-flagged request skips DIV and goes IDLE → ROUND.
  - DIV_o = 0x0000 and done_o appear at edge N+2.
  - Overflow and underflow are only known after iteration, so they keep full latency.
- FPDIV_EARLY_EXIT_EN undefined: every request, flushed or not, takes exactly 14 cycles.

## Test plan
- 0x4000 / 0x3C00 (2/1) → DIV_o = 0x4000, done_o at N+14, busy_o high N..N+14.
- 0x3C00 / 0x4200 (1/3) → 0x3555 (guard 0). 0x4500 / 0x4200 (5/3) → 0x3EAB (round-up path). 0xC500 / 0x4000 (−5/2) → 0xC100.
- 0x4000 / 0x0000, 0x7C00 / 0x4000, and 0x0000 / 0x4000 each → 0x0000.
  - With FPDIV_EARLY_EXIT_EN: done_o at N+2.
  - Without it: done_o at N+14.
- 0x7BFF / 0x0400 (overflow) → 0x0000 at N+14. 0x0400 / 0x7800 (underflow) → 0x0000 at N+14, in both builds.
- Accept 0x4000 / 0x3C00, then pulse start_i with 0x3C00 / 0x4200 at N+5 → single done_o at N+14 with 0x4000. No second done_o follows.
- Assert rst_i at N+7 of a 1/3 request → outputs return to 0 asynchronously and no done_o occurs. A fresh start after release completes normally with 0x3555.
